// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing one single-ported word memory between instruction fetch and load/store.
// Define MEM_ARB_RR_EN to make contested OPEN cycles round-robin instead of data-priority with a MAX_RUN bound.
module mem_port_arbiter #(
    parameter int unsigned MAX_RUN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req_valid,
    output logic        f_req_ready,
    input  logic [31:0] f_addr,
    output logic        f_rsp_valid,
    output logic [31:0] f_rsp_rdata,
    output logic        f_rsp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_lock,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_rdata,
    output logic        d_rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    typedef enum logic [0:0] {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] MAX_RUN_C = 4'(MAX_RUN);

    state_t      state_r;
    logic [3:0]  run_r;
    logic        last_gnt_d_r;
    logic        gnt_f_s;
    logic        gnt_d_s;
    logic        f_err_s;
    logic        d_err_s;
    logic        f_rsp_valid_r;
    logic        f_rsp_err_r;
    logic [31:0] f_rsp_rdata_r;
    logic        d_rsp_valid_r;
    logic        d_rsp_err_r;
    logic [31:0] d_rsp_rdata_r;

    // Only word-aligned addresses inside the 64 KiB window reach the memory.
    function automatic logic addr_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr[31:16] != 16'h0000);
    endfunction

    assign f_err_s = addr_err(f_addr);
    assign d_err_s = addr_err(d_addr);

    // Grant selection; ready is the grant itself so it never rises without valid.
    always_comb begin
        gnt_f_s = 1'b0;
        gnt_d_s = 1'b0;
        if (!rst_n) begin
            gnt_f_s = 1'b0;
            gnt_d_s = 1'b0;
        end else if (state_r == ST_LOCKED) begin
            gnt_d_s = d_req_valid;
        end else if (f_req_valid && d_req_valid) begin
`ifdef MEM_ARB_RR_EN
            gnt_d_s = !last_gnt_d_r;
`else
            if (run_r < MAX_RUN_C) begin
                gnt_d_s = 1'b1;
            end else begin
                gnt_d_s = !last_gnt_d_r;
            end
`endif
            gnt_f_s = !gnt_d_s;
        end else begin
            gnt_f_s = f_req_valid;
            gnt_d_s = d_req_valid;
        end
    end

    assign f_req_ready = gnt_f_s;
    assign d_req_ready = gnt_d_s;

    // Memory port drive; the memory read is combinational so these cannot be registered.
    always_comb begin
        if (gnt_d_s) begin
            mem_addr = d_addr;
            mem_wd   = d_wdata;
            mem_we   = d_req_we && !d_err_s;
        end else if (gnt_f_s) begin
            mem_addr = f_addr;
            mem_wd   = d_wdata;
            mem_we   = 1'b0;
        end else begin
            mem_addr = 32'h0000_0000;
            mem_wd   = 32'h0000_0000;
            mem_we   = 1'b0;
        end
    end

    // Lock FSM, run counter and last-grant tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_OPEN;
            run_r        <= 4'd0;
            last_gnt_d_r <= 1'b0;
        end else begin
            case (state_r)
                ST_OPEN: begin
                    if (gnt_d_s && d_lock) begin
                        state_r <= ST_LOCKED;
                    end else begin
                        state_r <= ST_OPEN;
                    end
                    if (gnt_f_s || gnt_d_s) begin
                        if (gnt_d_s != last_gnt_d_r) begin
                            run_r <= 4'd1;
                        end else if ((gnt_d_s ? f_req_valid : d_req_valid) && (run_r != 4'd15)) begin
                            run_r <= run_r + 4'd1;
                        end else begin
                            run_r <= run_r;
                        end
                        last_gnt_d_r <= gnt_d_s;
                    end else begin
                        run_r        <= 4'd0;
                        last_gnt_d_r <= last_gnt_d_r;
                    end
                end
                ST_LOCKED: begin
                    if (gnt_d_s && !d_lock) begin
                        state_r <= ST_OPEN;
                    end else begin
                        state_r <= ST_LOCKED;
                    end
                    if (gnt_d_s) begin
                        last_gnt_d_r <= 1'b1;
                    end else begin
                        last_gnt_d_r <= last_gnt_d_r;
                    end
                    run_r <= run_r;
                end
                default: begin
                    state_r      <= ST_OPEN;
                    run_r        <= 4'd0;
                    last_gnt_d_r <= 1'b0;
                end
            endcase
        end
    end

    // One-cycle responses captured on the edge that ends the accept cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rsp_valid_r <= 1'b0;
            f_rsp_err_r   <= 1'b0;
            f_rsp_rdata_r <= 32'h0000_0000;
            d_rsp_valid_r <= 1'b0;
            d_rsp_err_r   <= 1'b0;
            d_rsp_rdata_r <= 32'h0000_0000;
        end else begin
            f_rsp_valid_r <= gnt_f_s;
            f_rsp_err_r   <= gnt_f_s && f_err_s;
            f_rsp_rdata_r <= (gnt_f_s && !f_err_s) ? mem_rd : 32'h0000_0000;
            d_rsp_valid_r <= gnt_d_s;
            d_rsp_err_r   <= gnt_d_s && d_err_s;
            d_rsp_rdata_r <= (gnt_d_s && !d_err_s && !d_req_we) ? mem_rd : 32'h0000_0000;
        end
    end

    assign f_rsp_valid = f_rsp_valid_r;
    assign f_rsp_err   = f_rsp_err_r;
    assign f_rsp_rdata = f_rsp_rdata_r;
    assign d_rsp_valid = d_rsp_valid_r;
    assign d_rsp_err   = d_rsp_err_r;
    assign d_rsp_rdata = d_rsp_rdata_r;

endmodule
